// File: rtl/lsu_bridge.sv
// lsu_bridge: load/store unit bridging a single-cycle CPU data port to a
// variable-latency word-addressed memory bus (valid/ready request channel,
// valid-only response channel). Loads come back lane-extracted and
// sign/zero-extended; stores are replicated to byte lanes with strobes.
// Optional macro LSU_MISALIGN_CHK_EN: misaligned H/W requests are rejected
// with a bus_err pulse instead of being silently force-aligned.
module lsu_bridge #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_wen,
  input  logic [2:0]  memop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata,
  output logic        stall,
  output logic [31:0] mem_data,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q,    state_d;
  logic [31:0]      addr_q,     addr_d;
  logic [2:0]       op_q,       op_d;
  logic             wen_q,      wen_d;
  logic [3:0]       wstrb_q,    wstrb_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic             bus_err_q,  bus_err_d;

  logic [3:0]  req_strb;
  logic [31:0] req_wdata;
  logic        req_misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Decode an incoming CPU request into bus lane strobes and replicated data.
  // memop[1:0] picks the size: 00 byte, 01 half, anything with bit1 set is a
  // word (this also folds the reserved encodings 011/110/111 into W).
  always_comb begin
    req_strb     = 4'b0000;
    req_wdata    = 32'h0;
    req_misalign = 1'b0;
    case (memop[1:0])
      2'b00: begin
        req_strb  = 4'b0001 << mem_addr[1:0];
        req_wdata = {4{memdata[7:0]}};
      end
      2'b01: begin
        req_strb     = 4'b0011 << {mem_addr[1], 1'b0};
        req_wdata    = {2{memdata[15:0]}};
        req_misalign = mem_addr[0];
      end
      default: begin
        req_strb     = 4'b1111;
        req_wdata    = memdata;
        req_misalign = |mem_addr[1:0];
      end
    endcase
    if (!mem_wen) begin
      req_strb  = 4'b0000;
      req_wdata = 32'h0;
    end
  end

  // Extract and extend the load result from the raw response word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = op_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = bus_rdata;
    endcase
    if (wen_q) begin
      load_ext = 32'h0;
    end
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  // Access sequencer: capture in IDLE, hold the request in REQ until accepted,
  // wait for the response (or the timeout), present the result in DONE.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wen_d      = wen_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          addr_d     = mem_addr;
          op_d       = memop;
          wen_d      = mem_wen;
          wstrb_d    = req_strb;
          wdata_d    = req_wdata;
          mem_data_d = 32'h0;
          state_d    = ST_REQ;
`ifdef LSU_MISALIGN_CHK_EN
          if (req_misalign) begin
            // Rejected before touching the bus; present no write on the bus.
            wen_d     = 1'b0;
            wstrb_d   = 4'b0000;
            wdata_d   = 32'h0;
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end
`endif
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_req_ready && bus_resp_valid) begin
          mem_data_d = load_ext;
          state_d    = ST_DONE;
        end else if (timeout_hit) begin
          mem_data_d = 32'h0;
          bus_err_d  = 1'b1;
          state_d    = ST_DONE;
        end else if (bus_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_resp_valid) begin
          mem_data_d = load_ext;
          state_d    = ST_DONE;
        end else if (timeout_hit) begin
          mem_data_d = 32'h0;
          bus_err_d  = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: begin
        // DONE: the CPU retires this access on the coming edge.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0;
      op_q       <= 3'b000;
      wen_q      <= 1'b0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      cnt_q      <= '0;
      mem_data_q <= 32'h0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wen_q      <= wen_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // stall is gated by reset so every output reads 0 while reset is held.
  assign stall         = rst & req_valid & (state_q != ST_DONE);
  assign mem_data      = mem_data_q;
  assign bus_err       = bus_err_q;
  assign bus_req_valid = (state_q == ST_REQ);
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_wen       = wen_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// Testbench for lsu_bridge: a scripted bus responder per access, with the
// expected CPU-side result queued when the request is driven and checked
// when stall drops (DONE).
module tb_lsu_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_wen;
  logic [2:0]  memop;
  logic [31:0] mem_addr;
  logic [31:0] memdata;
  logic        stall;
  logic [31:0] mem_data;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsu_bridge #(.TIMEOUT_CYC(TO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_wen(mem_wen),
    .memop(memop), .mem_addr(mem_addr), .memdata(memdata), .stall(stall),
    .mem_data(mem_data), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_strb(input logic w, input logic [2:0] op, input logic [31:0] a);
    if (!w) return 4'b0000;
    if (op == 3'b000 || op == 3'b100) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (op == 3'b001 || op == 3'b101) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
    if (op == 3'b000 || op == 3'b100) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (op == 3'b001 || op == 3'b101) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[8*a[1:0] +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    case (op)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return r;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'b000 || op == 3'b100) return 1'b0;
    if (op == 3'b001 || op == 3'b101) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  // One CPU access with a scripted bus: ready after rdy_dly REQ cycles,
  // response rsp_dly WAIT cycles after ready (0 = same cycle, <0 = never).
  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int rdy_dly, input int rsp_dly);
    exp_t e;
    logic mis_err;
    logic skip_first;
    logic ready_given;
    logic done;
    int   exp_stall;
    int   stall_cnt;
    int   req_cyc;
    int   wcnt;
    int   cyc;
    logic [36:0] exp_bus;
`ifdef LSU_MISALIGN_CHK_EN
    mis_err = m_mis(op, a);
`else
    mis_err = 1'b0;
`endif
    if (mis_err) begin
      e.data = 32'h0; e.err = 1'b1; exp_stall = 1;
    end else if (rsp_dly < 0) begin
      e.data = 32'h0; e.err = 1'b1; exp_stall = 1 + TO;
    end else begin
      e.data = w ? 32'h0 : m_load(op, a, rd); e.err = 1'b0;
      exp_stall = 2 + rdy_dly + rsp_dly;
    end
    sb_q.push_back(e);
    exp_bus = {a[31:2], 2'b00, m_strb(w, op, a), w};

    req_valid = 1'b1; mem_wen = w; memop = op; mem_addr = a; memdata = d;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = rd;
    #1;
    skip_first  = !stall;
    stall_cnt   = stall ? 1 : 0;
    ready_given = 1'b0;
    done        = 1'b0;
    req_cyc     = 0;
    wcnt        = 0;
    cyc         = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        errors++; checks++;
        $display("FAIL access_bound addr=%08h: no DONE within 200 cycles", a);
        done = 1'b1;
      end else if (skip_first) begin
        skip_first = 1'b0;
        if (stall) stall_cnt++;
      end else if (!stall) begin
        e = sb_q.pop_front();
        checks++;
        if (mem_data !== e.data) begin
          errors++;
          $display("FAIL mem_data addr=%08h op=%03b: got %08h want %08h", a, op, mem_data, e.data);
        end
        checks++;
        if (bus_err !== e.err) begin
          errors++;
          $display("FAIL bus_err addr=%08h op=%03b: got %0b want %0b", a, op, bus_err, e.err);
        end
        checks++;
        if (stall_cnt != exp_stall) begin
          errors++;
          $display("FAIL stall_cycles addr=%08h op=%03b: got %0d want %0d", a, op, stall_cnt, exp_stall);
        end
        $display("txn w=%0b op=%03b addr=%08h mem_data=%08h err=%0b stall=%0d", w, op, a, mem_data, bus_err, stall_cnt);
        done = 1'b1;
      end else begin
        stall_cnt++;
        if (bus_req_valid) begin
          checks++;
          if (mis_err || {bus_addr, bus_wstrb, bus_wen} !== exp_bus) begin
            errors++;
            $display("FAIL bus_req addr=%08h: got addr=%08h strb=%04b wen=%0b want addr=%08h strb=%04b wen=%0b mis=%0b",
                     a, bus_addr, bus_wstrb, bus_wen, exp_bus[36:5], exp_bus[4:1], exp_bus[0], mis_err);
          end
          if (w) begin
            checks++;
            if (bus_wdata !== m_wdata(op, d)) begin
              errors++;
              $display("FAIL bus_wdata addr=%08h: got %08h want %08h", a, bus_wdata, m_wdata(op, d));
            end
          end
          if (req_cyc == rdy_dly) begin
            bus_req_ready = 1'b1;
            ready_given   = 1'b1;
            bus_resp_valid = (rsp_dly == 0);
          end
          req_cyc++;
        end else begin
          if (!ready_given) begin
            errors++; checks++;
            $display("FAIL req_valid_drop addr=%08h: bus_req_valid 0 before ready, want 1", a);
          end
          bus_req_ready = 1'b0;
          wcnt++;
          bus_resp_valid = (wcnt == rsp_dly);
        end
      end
    end
    req_valid = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; mem_wen = 1'b0; memop = 3'b000;
    mem_addr = 32'h0; memdata = 32'h0; bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++;
    if ({stall, bus_err, bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata, mem_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%0b err=%0b rv=%0b wen=%0b addr=%08h strb=%04b wdata=%08h md=%08h want all 0",
               stall, bus_err, bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata, mem_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0); // LB
    @(negedge clk);
    access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h9ABC_5678, 0, 5); // LHU
    @(negedge clk);
    access(1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h1122_F344, 1, 2); // LBU
    @(negedge clk);
    access(1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h0000_8001, 0, 1); // LH
    @(negedge clk);
    access(1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 2, 0); // LW
    @(negedge clk);
    access(1'b0, 3'b011, 32'h0000_3008, 32'h0, 32'h8765_4321, 0, 1); // reserved -> W
  endtask

  task automatic test_stores();
    @(negedge clk);
    access(1'b1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1); // SH
    @(negedge clk);
    access(1'b1, 3'b000, 32'h0000_0011, 32'hAAAA_AA5C, 32'h0, 0, 0);         // SB
    @(negedge clk);
    access(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 1, 1);         // SW
  endtask

  task automatic test_ready_stall();
    @(negedge clk);
    access(1'b1, 3'b000, 32'h0000_0402, 32'h0000_00E7, 32'h0, 4, 1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    access(1'b0, 3'b000, 32'h0000_0500, 32'h0, 32'h0000_007F, 0, 0);
    access(1'b1, 3'b101, 32'h0000_0502, 32'h0000_BEEF, 32'h0, 0, 0);
    access(1'b0, 3'b001, 32'h0000_0502, 32'h0, 32'hBEEF_0000, 1, 1);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1234_5678, 0, -1);
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL bus_err_pulse: got %0b one cycle after DONE, want 0", bus_err);
    end
    access(1'b0, 3'b010, 32'h0000_0604, 32'h0, 32'h1234_5678, 3, -1);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    access(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'hDEAD_BEEF, 0, 0); // LW misaligned
    @(negedge clk);
    access(1'b0, 3'b001, 32'h8000_0003, 32'h0, 32'h8765_4321, 0, 1); // LH misaligned
    @(negedge clk);
    access(1'b1, 3'b010, 32'h8000_0012, 32'h0BAD_F00D, 32'h0, 0, 0); // SW misaligned
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 1'b1; mem_wen = 1'b1; memop = 3'b010; mem_addr = 32'h0000_0040;
    memdata = 32'h5555_AAAA; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    @(negedge clk);           // REQ
    bus_req_ready = 1'b1;
    @(negedge clk);           // WAIT
    bus_req_ready = 1'b0;
    checks++;
    if (bus_addr !== 32'h0000_0040 || stall !== 1'b1 || bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_wait: got addr=%08h stall=%0b rv=%0b want 00000040/1/0", bus_addr, stall, bus_req_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({stall, bus_err, bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata, mem_data} !== '0) begin
      errors++;
      $display("FAIL async_reset: got stall=%0b err=%0b rv=%0b wen=%0b addr=%08h strb=%04b wdata=%08h md=%08h want all 0",
               stall, bus_err, bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata, mem_data);
    end
    $display("txn async_reset in WAIT addr=%08h stall=%0b", bus_addr, stall);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // late response in IDLE must be ignored
    bus_resp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    checks++;
    if (mem_data !== 32'h0 || stall !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL late_resp: got md=%08h stall=%0b err=%0b want 0/0/0", mem_data, stall, bus_err);
    end
    access(1'b0, 3'b000, 32'h0000_0041, 32'h0, 32'h0000_9900, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_ready_stall();
    test_back_to_back();
    test_timeout();
    test_misalign();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_bridge.md
Name: lsu_bridge

Overview:
- Load/store unit between the single-cycle riscv_cpu data port and a variable-latency data memory bus.
- Upstream (CPU) side: accepts one request per instruction as memop/mem_addr/memdata/mem_wen, stalls the CPU until the access completes, and returns load data aligned and sign/zero-extended.
- Downstream (bus) side: issues word-aligned requests with byte strobes over a valid/ready request channel and a valid-only response channel.

Parameters:
- TIMEOUT_CYC, 256: cycles in REQ+WAIT after which the access is abandoned with an error.
- CNT_W, 9: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU has a load or store this cycle.
- mem_wen  in  1  1 = store, 0 = load.
- memop  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_addr  in  32  byte address.
- memdata  in  32  store data, right-justified.
- stall  out  1  hold the CPU PC/regfile write.
- mem_data  out  32  extended load result; valid while state=DONE.
- bus_err  out  1  one-cycle pulse on timeout (or misalign, see below).
- bus_req_valid  out  1  request channel valid.
- bus_req_ready  in  1  request channel ready.
- bus_addr  out  32  {mem_addr[31:2],2'b00}.
- bus_wen  out  1  write request.
- bus_wstrb  out  4  byte lane enables.
- bus_wdata  out  32  store data replicated/shifted to lanes.
- bus_resp_valid  in  1  response valid; always accepted.
- bus_rdata  in  32  raw word read data.

Behaviour:
- Reset (rst=0, async): state=IDLE; stall, bus_err, bus_req_valid, bus_wen=0; bus_addr, bus_wstrb, bus_wdata, mem_data=0; counter=0.
- FSM IDLE->REQ->WAIT->DONE->IDLE.
- IDLE: on req_valid, register addr/op/wen/data into the request registers and go to REQ.
- REQ: bus_req_valid=1. All bus outputs stay stable until bus_req_ready=1, then go to WAIT. If bus_resp_valid is already 1 in that same cycle, go straight to DONE.
- WAIT: on bus_resp_valid, capture the extended result into mem_data and go to DONE. For stores the response is an ack only and mem_data=0.
- DONE: stall=0, mem_data valid, go to IDLE next cycle. The CPU advances on this edge; its still-asserted req_valid in DONE is not re-issued.
- stall = req_valid & (state != DONE). Combinational, so stall rises in the same cycle as a new request. Minimum access latency is 3 cycles (IDLE, REQ, DONE).
- Write lanes:
  - SB: wstrb = 0001<<a[1:0]; wdata = {4{d[7:0]}}.
  - SH: wstrb = 0011<<{a[1],1'b0}; wdata = {2{d[15:0]}}.
  - SW: wstrb = 1111; wdata = d.
  - Loads: wstrb = 0000.
- Load extract:
  - Byte: lane a[1:0]. Half: lane a[1]. Word: full word.
  - B/H sign-extend; BU/HU zero-extend.
- Reserved memop (011, 110, 111) are treated as W.
- Misalignment without the macro: natural alignment is forced. H ignores a[0]; W ignores a[1:0].
- Timeout: the counter increments every cycle in REQ and WAIT and clears in IDLE. At TIMEOUT_CYC-1: go to DONE, mem_data=0, bus_err=1 for one cycle, bus_req_valid drops.
- A late bus_resp_valid arriving in IDLE or DONE is ignored.
- Reset asserted mid-operation: immediate return to IDLE. The outstanding bus transaction is abandoned, with no retry.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: in IDLE, a misaligned H (a[0]=1) or W (a[1:0]!=0) request does not enter REQ. It goes directly to DONE with mem_data=0 and bus_err pulsed for one cycle, and no bus transaction is issued.
- Undefined: no check, forced alignment as above, and bus_err reports timeouts only.

Test Plan:
- LB at 0x8000_0003, bus_rdata=0x80FF_1234, ready and resp immediate -> bus_addr=0x8000_0000, stall high for 2 cycles, mem_data=0xFFFF_FF80 in DONE.
- LHU at 0x8000_0002, rdata=0x9ABC_5678, resp 5 cycles after ready -> mem_data=0x0000_9ABC, stall released exactly in the DONE cycle.
- SH at 0x8000_0006 with data 0x1234_ABCD -> bus_addr=0x8000_0004, bus_wstrb=1100, bus_wdata=0xABCD_ABCD, bus_wen=1.
- bus_req_ready held low 4 cycles -> bus_addr, bus_wstrb and bus_wdata stable throughout; bus_req_valid stays 1.
- No response with TIMEOUT_CYC=16 -> DONE reached 16 cycles after leaving IDLE; bus_err one-cycle pulse; mem_data=0.
- rst driven low while in WAIT, between clock edges -> state=IDLE and all outputs 0 without waiting for a clock edge. With LSU_MISALIGN_CHK_EN, LW at 0x...01 -> no bus_req_valid; bus_err pulse; mem_data=0.
